flt2fix_iter: RTL
=================

Name:
flt2fix_iter

Overview:
- Iterative float16 (1.5.10, bias 15) to fixed 8.8 two's-complement converter; the inverse of the program-1 fixed(8.8)-to-float16 stage.
- Consumes the 16-bit float that stage produces and returns the fixed value. Used as a hardware golden model beside the DUT, and as the datapath behind the program-2 benches.
- Shifts the 11-bit significand a few bits per cycle under a start/done handshake.

Parameters:
- SHIFT_PER_CYCLE, 1: bits shifted per SHIFT cycle; legal values 1, 2, 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- start  in  1  request; sampled only in IDLE.
- flt_in  in  16  float16 operand; captured on the accepted start edge.
- fix_out  out  16  fixed 8.8 result; held until the next accepted start.
- sat  out  1  result was saturated, or input was NaN.
- done  out  1  high in DONE until the next accepted start.
- busy  out  1  high in LOAD, SHIFT and FINAL.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: fix_out=0, sat=0, done=0, busy=0, state=IDLE. Reset mid-operation aborts, with no partial result visible.
- Field split: s=flt_in[15], e=flt_in[14:10], m=flt_in[9:0].
- Arithmetic: magnitude = {1,m} * 2^(e-17).
  - e>17: left shift by n=e-17.
  - e<17: right shift by n=17-e, truncating the magnitude toward zero.
  - e=17: n=0.
  - Negative inputs: negate the truncated magnitude.
- Special cases, all with n=0 and no shifting:
  - e=0 (zero/subnormal) -> 0x0000, sat=0. This includes -0.
  - e=31, m=0 -> 0x7FFF (s=0) or 0x8000 (s=1), sat=1.
  - e=31, m!=0 (NaN) -> 0x0000, sat=1.
  - 22<=e<=30 -> 0x7FFF (s=0) or 0x8000 (s=1), sat=1. Exception: 0xD800 (exactly -128.0) -> 0x8000 with sat=0.
  - 1<=e<=6 -> shifts proceed normally; magnitude reaches 0; result 0x0000.
- FSM:
  - IDLE: on start=1, capture flt_in, clear done -> LOAD.
  - LOAD: decode, compute n, load the 24-bit shift register -> SHIFT if n>0, else FINAL.
  - SHIFT: shift min(SHIFT_PER_CYCLE, remaining) bits per cycle; leave when remaining reaches 0 -> FINAL.
  - FINAL: negate or saturate, write fix_out and sat -> DONE.
  - DONE: done=1; start=1 -> LOAD with a new capture (back-to-back operation allowed).
- Latency: start accepted at edge k -> done rises after edge k+2+ceil(n/SHIFT_PER_CYCLE).
- Busy rules: start is ignored while busy, and flt_in changes after capture have no effect.
- start held high across DONE begins the next conversion immediately.

Optional Feature:
- Macro: FLT2FIX_ROUND_EN.
- Defined: right shifts track guard and sticky bits, and the magnitude is rounded to nearest, ties to even, before negation. A carry out of the rounding is re-checked against the saturation limit. Latency is unchanged.
- Undefined: truncation toward zero, and the guard/sticky logic is absent.

Decomposition:
- Shared package fp_conv_pkg:
  - Constants: FLT_BIAS=15, FIX_FRAC=8, EXP_W=5, MAN_W=10, FIX_MAX=16'h7FFF, FIX_MIN=16'h8000.
  - Types: the state enum (IDLE, LOAD, SHIFT, FINAL, DONE) and the float16 field struct.
- One sub-module, flt2fix_shifter: the shift register, remaining-count counter, and sticky/guard tracking.

Test Plan:
- 0x3C00 (1.0) -> fix_out=0x0100, sat=0, done at k+4 (SHIFT_PER_CYCLE=1); 0xBC00 -> 0xFF00.
- 0x1C00 (1/256) -> 0x0001, done at k+12; 0x57FF -> 0x7FF0, done at k+6.
- Saturation:
  - 0x5800 -> 0x7FFF, sat=1.
  - 0xD800 -> 0x8000, sat=0.
  - 0x7C00 -> 0x7FFF, sat=1.
  - 0x7E00 -> 0x0000, sat=1.
  - Each has done at k+2.
- 0x0000, 0x8000, 0x0200 -> 0x0000, sat=0; 0x1800 (e=6) -> 0x0000.
- Rounding on 0x3C03 and 0xBC03:
  - Without FLT2FIX_ROUND_EN: 0x0100 and 0xFF00.
  - With FLT2FIX_ROUND_EN: 0x0101 and 0xFEFF.
  - Tie case 0x3C02 -> 0x0100 in both builds.
- Control:
  - reset pulsed mid-SHIFT -> all outputs 0, state IDLE.
  - start pulsed while busy -> ignored.
  - 100 random inputs checked against the program-1 math model via round trip, including sweeps of SHIFT_PER_CYCLE=2 and 4.

Source files
------------

// File: rtl/fp_conv_pkg.sv
// Shared float16 <-> fixed 8.8 conversion types, constants and the float16 decoder.
// Latency: n/a (types, constants and a pure combinational helper function).
// Backpressure: n/a.
package fp_conv_pkg;

  localparam int FLT_BIAS = 15;
  localparam int FIX_FRAC = 8;
  localparam int EXP_W    = 5;
  localparam int MAN_W    = 10;
  localparam logic [15:0] FIX_MAX = 16'h7FFF;
  localparam logic [15:0] FIX_MIN = 16'h8000;

  localparam int SH_W  = 24;  // shift register width
  localparam int CNT_W = 5;   // shift distance is at most 16

  // Exponent at which {1,m} is already aligned to 8.8 (bias + MAN_W - FIX_FRAC = 17).
  localparam logic [EXP_W-1:0] ALIGN_EXP = EXP_W'(FLT_BIAS + MAN_W - FIX_FRAC);
  // First exponent whose smallest value (2^7 = 128.0) no longer fits in 8.8.
  localparam logic [EXP_W-1:0] SAT_EXP = EXP_W'(FLT_BIAS + 15 - FIX_FRAC);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, FINAL, DONE} state_t;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } flt16_t;

  // Result class; everything except K_NORM bypasses the shifter.
  typedef enum logic [2:0] {K_NORM, K_ZERO, K_NAN, K_SAT, K_NEG128} kind_t;

  typedef struct packed {
    kind_t            kind;
    logic             s;
    logic             left;  // 1: shift left, 0: shift right
    logic [CNT_W-1:0] n;     // shift distance
    logic [SH_W-1:0]  sig;   // {1,m} right-aligned
  } dec_t;

  function automatic dec_t f16_decode(input flt16_t f);
    dec_t d;
    d.kind = K_NORM;
    d.s    = f.s;
    d.left = 1'b0;
    d.n    = '0;
    d.sig  = SH_W'({1'b1, f.m});
    if (f.e == '0) begin
      d.kind = K_ZERO;
    end else if (f.e == '1) begin
      d.kind = (f.m == '0) ? K_SAT : K_NAN;
    end else if (f.e >= SAT_EXP) begin
      // -128.0 is the only value in the saturating band that fits exactly.
      d.kind = (f.s && f.e == SAT_EXP && f.m == '0) ? K_NEG128 : K_SAT;
    end else if (f.e > ALIGN_EXP) begin
      d.left = 1'b1;
      d.n    = CNT_W'(f.e - ALIGN_EXP);
    end else begin
      d.n    = CNT_W'(ALIGN_EXP - f.e);
    end
    return d;
  endfunction

endpackage

// File: rtl/flt2fix_iter_if.sv
// Request/result bundle of the iterative float16 -> fixed 8.8 converter.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the converter is not busy.
// Signals: start, flt_in[15:0] (requester -> converter); fix_out[15:0], sat, done, busy (back).
interface flt2fix_iter_if;
  logic        start;
  logic [15:0] flt_in;
  logic [15:0] fix_out;
  logic        sat;
  logic        done;
  logic        busy;

  modport master (output start, flt_in, input fix_out, sat, done, busy);
  modport slave  (input start, flt_in, output fix_out, sat, done, busy);
endinterface

// File: rtl/flt2fix_shifter.sv
// Significand shift register with remaining-distance counter (and guard/sticky when rounding).
// Latency: loads in one cycle, then min(SHIFT_PER_CYCLE, remaining) bits per enabled cycle.
// Backpressure: none; shifting advances only while shift_en is high.
// Ports: clk, reset, load, left, cnt_in, val_in, shift_en -> val, last [, guard, sticky].
// Macro FLT2FIX_ROUND_EN adds guard/sticky tracking for right shifts.
module flt2fix_shifter
  import fp_conv_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             left,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic [SH_W-1:0]  val_in,
  input  logic             shift_en,
  output logic [SH_W-1:0]  val,
  output logic             last
`ifdef FLT2FIX_ROUND_EN
  ,
  output logic             guard,
  output logic             sticky
`endif
);

  logic [SH_W-1:0]  val_q, val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             left_q;
`ifdef FLT2FIX_ROUND_EN
  logic             grd_q, grd_d, stk_q, stk_d;
`endif

  // Unrolled single-bit steps; steps beyond the remaining distance are no-ops.
  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q;
`ifdef FLT2FIX_ROUND_EN
    grd_d = grd_q;
    stk_d = stk_q;
`endif
    for (int i = 0; i < SHIFT_PER_CYCLE; i++) begin
      if (cnt_d != '0) begin
        if (left_q) begin
          val_d = {val_d[SH_W-2:0], 1'b0};
        end else begin
`ifdef FLT2FIX_ROUND_EN
          stk_d = stk_d | grd_d;
          grd_d = val_d[0];
`endif
          val_d = {1'b0, val_d[SH_W-1:1]};
        end
        cnt_d = cnt_d - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q  <= '0;
      cnt_q  <= '0;
      left_q <= 1'b0;
`ifdef FLT2FIX_ROUND_EN
      grd_q  <= 1'b0;
      stk_q  <= 1'b0;
`endif
    end else if (load) begin
      val_q  <= val_in;
      cnt_q  <= cnt_in;
      left_q <= left;
`ifdef FLT2FIX_ROUND_EN
      grd_q  <= 1'b0;
      stk_q  <= 1'b0;
`endif
    end else if (shift_en) begin
      val_q  <= val_d;
      cnt_q  <= cnt_d;
`ifdef FLT2FIX_ROUND_EN
      grd_q  <= grd_d;
      stk_q  <= stk_d;
`endif
    end
  end

  assign val  = val_q;
  // This cycle's step finishes the remaining distance.
  assign last = (cnt_q <= CNT_W'(SHIFT_PER_CYCLE));
`ifdef FLT2FIX_ROUND_EN
  assign guard  = grd_q;
  assign sticky = stk_q;
`endif

endmodule

// File: rtl/flt2fix_iter.sv
// Iterative float16 (1.5.10, bias 15) to fixed 8.8 two's-complement converter.
// Latency: start accepted at edge k -> done after edge k+2+ceil(n/SHIFT_PER_CYCLE).
// Backpressure: start ignored while busy; done held (and result held) until next accepted start.
// Ports: clk, reset (async, active-high), bus (flt2fix_iter_if.slave: start, flt_in, fix_out, sat, done, busy).
// Macro FLT2FIX_ROUND_EN: round-to-nearest-even on right shifts instead of truncation.
module flt2fix_iter
  import fp_conv_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = 1  // 1, 2 or 4
) (
  input  logic           clk,
  input  logic           reset,
  flt2fix_iter_if.slave  bus
);

  state_t          state, nstate;
  flt16_t          flt_q;
  dec_t            dec;
  logic [15:0]     fix_q, res;
  logic            sat_q, res_sat;
  logic            cap, ld, shift_en, fin_wr, busy_c, done_c;
  logic [SH_W-1:0] sh_val;
  logic            sh_last;
  logic [16:0]     mag;
`ifdef FLT2FIX_ROUND_EN
  logic            sh_guard, sh_sticky;
`endif

  // flt_q is stable from LOAD to DONE, so one decoder serves both LOAD and FINAL.
  assign dec = f16_decode(flt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate   = state;
    cap      = 1'b0;
    ld       = 1'b0;
    shift_en = 1'b0;
    fin_wr   = 1'b0;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          cap    = 1'b1;
          nstate = LOAD;
        end
      end
      LOAD: begin
        busy_c = 1'b1;
        ld     = 1'b1;
        nstate = (dec.n != '0) ? SHIFT : FINAL;
      end
      SHIFT: begin
        busy_c   = 1'b1;
        shift_en = 1'b1;
        if (sh_last) nstate = FINAL;
      end
      FINAL: begin
        busy_c = 1'b1;
        fin_wr = 1'b1;
        nstate = DONE;
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          cap    = 1'b1;
          nstate = LOAD;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  flt2fix_shifter #(.SHIFT_PER_CYCLE(SHIFT_PER_CYCLE)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .left     (dec.left),
    .cnt_in   (dec.n),
    .val_in   (dec.sig),
    .shift_en (shift_en),
    .val      (sh_val),
    .last     (sh_last)
`ifdef FLT2FIX_ROUND_EN
    ,
    .guard    (sh_guard),
    .sticky   (sh_sticky)
`endif
  );

  // Final stage: optional rounding, then rail checks, then sign.
  always_comb begin
    mag     = {1'b0, sh_val[15:0]};
    res     = '0;
    res_sat = 1'b0;
`ifdef FLT2FIX_ROUND_EN
    if (sh_guard && (sh_sticky || sh_val[0])) mag = mag + 17'd1;
`endif
    case (dec.kind)
      K_ZERO:   res = '0;
      K_NAN:    res_sat = 1'b1;
      K_SAT: begin
        res     = dec.s ? FIX_MIN : FIX_MAX;
        res_sat = 1'b1;
      end
      K_NEG128: res = FIX_MIN;
      default: begin
        // A rounding carry can push the magnitude past the rail, so check after it.
        if (sh_val[SH_W-1:16] != '0 ||
            (!dec.s && mag > {1'b0, FIX_MAX}) ||
            ( dec.s && mag > {1'b0, FIX_MIN})) begin
          res     = dec.s ? FIX_MIN : FIX_MAX;
          res_sat = 1'b1;
        end else begin
          res = dec.s ? (~mag[15:0] + 16'd1) : mag[15:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flt_q <= '0;
      fix_q <= '0;
      sat_q <= 1'b0;
    end else begin
      if (cap)    flt_q <= bus.flt_in;
      if (fin_wr) begin
        fix_q <= res;
        sat_q <= res_sat;
      end
    end
  end

  assign bus.fix_out = fix_q;
  assign bus.sat     = sat_q;
  assign bus.done    = done_c;
  assign bus.busy    = busy_c;

endmodule
